// File: rtl/cv32e40p_xmem_obi_responder.sv
// Xmem load/store responder: takes one coprocessor memory request at a time,
// performs it as an OBI data-bus master and returns data/status on the Xmem response channel.
package cv32e40p_x_if_pkg;
  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01
  } mem_req_type_e;
endpackage

module cv32e40p_xmem_obi_responder
  import cv32e40p_x_if_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          xmem_valid_i,
  output logic          xmem_ready_o,
  input  logic [31:0]   xmem_laddr_i,
  input  logic [31:0]   xmem_wdata_i,
  input  logic [2:0]    xmem_width_i,
  input  mem_req_type_e xmem_req_type_i,
  input  logic          xmem_mode_i,
  input  logic          xmem_spec_i,
  input  logic          xmem_endoftransaction_i,
  output logic          xmem_rvalid_o,
  input  logic          xmem_rready_i,
  output logic [31:0]   xmem_rdata_o,
  output logic [4:0]    xmem_range_o,
  output logic          xmem_status_o,
  output logic          data_req_o,
  output logic          data_we_o,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  output logic [31:0]   data_addr_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_wdata_o,
  input  logic [31:0]   data_rdata_i
);

  typedef enum logic [2:0] {IDLE, BUS_REQ, BUS_WAIT, RESP, ERR_RESP} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  width;
    logic        we;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_write, illegal;
  logic [31:0] rd_shift, rd_ext, wdata_lanes;
  logic [3:0]  be;
  logic        unused_sideband;

  assign unused_sideband = xmem_mode_i ^ xmem_endoftransaction_i;
  assign is_write        = (xmem_req_type_i == WRITE);

  // Legality is decided on the request itself so an illegal access never touches the bus.
  always_comb begin
    illegal = 1'b0;
    case (xmem_width_i)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = xmem_laddr_i[0];
      3'b010:  illegal = |xmem_laddr_i[1:0];
      3'b100:  illegal = is_write;
      3'b101:  illegal = is_write | xmem_laddr_i[0];
      default: illegal = 1'b1;
    endcase
    if (is_write && xmem_spec_i) illegal = 1'b1;
  end

  always_comb begin
    case (req_q.width[1:0])
      2'b00: begin
        be          = 4'b0001 << req_q.addr[1:0];
        wdata_lanes = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be          = 4'b0011 << req_q.addr[1:0];
        wdata_lanes = {2{req_q.wdata[15:0]}};
      end
      default: begin
        be          = 4'b1111;
        wdata_lanes = req_q.wdata;
      end
    endcase
  end

  assign rd_shift = data_rdata_i >> {req_q.addr[1:0], 3'b000};

  always_comb begin
    case (req_q.width)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (xmem_valid_i) begin
          req_d   = '{addr: xmem_laddr_i, wdata: xmem_wdata_i, width: xmem_width_i, we: is_write};
          state_d = illegal ? ERR_RESP : BUS_REQ;
        end
      end
      BUS_REQ:  if (data_gnt_i) state_d = BUS_WAIT;
      BUS_WAIT: begin
        if (data_rvalid_i) begin
          rdata_d = req_q.we ? 32'h0 : rd_ext;
          state_d = RESP;
        end
      end
      RESP, ERR_RESP: if (xmem_rready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are gated by state so every idle output reads zero.
  assign xmem_ready_o  = (state_q == IDLE);
  assign xmem_rvalid_o = (state_q == RESP) || (state_q == ERR_RESP);
  assign xmem_rdata_o  = (state_q == RESP) ? rdata_q : 32'h0;
  assign xmem_range_o  = xmem_rvalid_o ? {req_q.addr[1:0], 3'b000} : 5'h0;
  assign xmem_status_o = (state_q == ERR_RESP);

  assign data_req_o    = (state_q == BUS_REQ);
  assign data_we_o     = data_req_o & req_q.we;
  assign data_addr_o   = data_req_o ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign data_be_o     = data_req_o ? be : 4'h0;
  assign data_wdata_o  = data_req_o ? wdata_lanes : 32'h0;

endmodule

// File: tb/tb_cv32e40p_xmem_obi_responder.sv
// Scoreboard bench: a byte-level memory model predicts Xmem responses and OBI beats;
// an OBI slave process and a response monitor check the DUT independently of the driver.
module tb_cv32e40p_xmem_obi_responder;
  import cv32e40p_x_if_pkg::*;

  typedef struct { logic [31:0] rdata; logic [4:0] rng; logic status; int lat; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;

  logic clk = 0, rst_i;
  logic xmem_valid_i, xmem_ready_o, xmem_mode_i, xmem_spec_i, xmem_endoftransaction_i;
  logic [31:0] xmem_laddr_i, xmem_wdata_i;
  logic [2:0] xmem_width_i;
  mem_req_type_e xmem_req_type_i;
  logic xmem_rvalid_o, xmem_rready_i, xmem_status_o;
  logic [31:0] xmem_rdata_o;
  logic [4:0] xmem_range_o;
  logic data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0] data_be_o;

  cv32e40p_xmem_obi_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .xmem_valid_i(xmem_valid_i), .xmem_ready_o(xmem_ready_o),
    .xmem_laddr_i(xmem_laddr_i), .xmem_wdata_i(xmem_wdata_i),
    .xmem_width_i(xmem_width_i), .xmem_req_type_i(xmem_req_type_i),
    .xmem_mode_i(xmem_mode_i), .xmem_spec_i(xmem_spec_i),
    .xmem_endoftransaction_i(xmem_endoftransaction_i),
    .xmem_rvalid_o(xmem_rvalid_o), .xmem_rready_i(xmem_rready_i),
    .xmem_rdata_o(xmem_rdata_o), .xmem_range_o(xmem_range_o), .xmem_status_o(xmem_status_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  rsp_t rsp_q[$];
  bus_t bus_q[$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bus_mem [int unsigned];
  int gnt_hold = 0, rv_dly = 1, rr_mode = 1, acc_cyc = 0, req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] x, input int k);
    return 8'(x >> (8 * k));
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
    return byte_of(w, int'(a % 4));
  endfunction

  task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
    w[8 * (a % 4) +: 8] = b;
    ref_mem[a >> 2] = w;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    ref_mem[a >> 2] = w;
    bus_mem[a >> 2] = w;
  endtask

  // Predict the transaction from the access rules, queue the expectations, then present it.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] w,
                       input bit wr, input bit sp, input bit lat_chk);
    int n, t;
    bit sgn, ok;
    rsp_t r;
    bus_t b;
    logic [31:0] v;
    n   = 1 << w[1:0];
    sgn = (w[2] == 1'b0);
    ok  = (w inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && ((a & (n - 1)) == 0) && !(wr && (w[2] || sp));
    r.rng = 5'(8 * (a % 4));
    r.status = !ok;
    r.rdata = 32'h0;
    r.lat = ok ? (lat_chk ? 3 : -1) : 1;
    if (ok) begin
      b.addr = a & ~32'h3;
      b.we = wr;
      b.be = 4'h0;
      b.wdata = 32'h0;
      for (int k = 0; k < n; k++) b.be[(a % 4) + k] = 1'b1;
      for (int l = 0; l < 4; l++) b.wdata[8 * l +: 8] = byte_of(wd, l % n);
      if (wr) begin
        for (int k = 0; k < n; k++) put_byte(a + k, byte_of(wd, k));
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v |= 32'(get_byte(a + k)) << (8 * k);
        if (sgn && n < 4 && v[8 * n - 1]) v |= ~32'h0 << (8 * n);
        r.rdata = v;
      end
      bus_q.push_back(b);
    end
    rsp_q.push_back(r);
    xmem_valid_i = 1;
    xmem_laddr_i = a;
    xmem_wdata_i = wd;
    xmem_width_i = w;
    xmem_req_type_i = wr ? WRITE : READ;
    xmem_spec_i = sp;
    xmem_mode_i = 1'($urandom);
    xmem_endoftransaction_i = 1'($urandom);
    t = 0;
    while (!xmem_ready_o) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        chk("accept_timeout", 32'(xmem_ready_o), 32'h1);
        finish_now();
      end
    end
    acc_cyc = cyc;
    @(negedge clk);
    xmem_valid_i = 0;
    xmem_laddr_i = $urandom;
    xmem_wdata_i = $urandom;
    xmem_width_i = 3'($urandom);
  endtask

  task automatic wait_done();
    int t = 0;
    while (rsp_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        chk("response_timeout", 32'(rsp_q.size()), 32'h0);
        finish_now();
      end
    end
  endtask

  // OBI slave: grants, checks each beat against the expected queue, answers from its own memory.
  initial begin
    int rv_cnt, wait_n;
    bit prev_pend;
    bus_t prev, e;
    logic [31:0] rd_word, w;
    rv_cnt = 0; wait_n = 0; prev_pend = 0; rd_word = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    forever begin
      @(negedge clk);
      data_gnt_i = 0;
      data_rvalid_i = 0;
      data_rdata_i = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          data_rvalid_i = 1;
          data_rdata_i = rd_word;
        end
      end
      if (data_req_o === 1'b1) begin
        if (prev_pend) begin
          chk("obi_hold_addr", data_addr_o, prev.addr);
          chk("obi_hold_be", 32'(data_be_o), 32'(prev.be));
          chk("obi_hold_we", 32'(data_we_o), 32'(prev.we));
          chk("obi_hold_wdata", data_wdata_o, prev.wdata);
        end else begin
          req_cycles++;
          chk("obi_req_expected", 32'(bus_q.size() != 0), 32'h1);
        end
        if ((gnt_hold >= 0) ? (wait_n >= gnt_hold) : ($urandom % 2 == 0)) begin
          data_gnt_i = 1;
          prev_pend = 0;
          wait_n = 0;
          if (bus_q.size() != 0) begin
            e = bus_q.pop_front();
            chk("obi_addr", data_addr_o, e.addr);
            chk("obi_we", 32'(data_we_o), 32'(e.we));
            chk("obi_be", 32'(data_be_o), 32'(e.be));
            if (e.we) chk("obi_wdata", data_wdata_o, e.wdata);
          end
          w = bus_mem.exists(data_addr_o >> 2) ? bus_mem[data_addr_o >> 2] : 32'h0;
          if (data_we_o) begin
            for (int l = 0; l < 4; l++) if (data_be_o[l]) w[8 * l +: 8] = data_wdata_o[8 * l +: 8];
            bus_mem[data_addr_o >> 2] = w;
            rd_word = $urandom;
          end else begin
            rd_word = w;
          end
          rv_cnt = (rv_dly > 0) ? rv_dly : int'($urandom_range(1, 3));
        end else begin
          prev_pend = 1;
          prev.addr = data_addr_o; prev.be = data_be_o; prev.we = data_we_o; prev.wdata = data_wdata_o;
          wait_n++;
        end
      end else begin
        prev_pend = 0;
        wait_n = 0;
        if (rv_cnt == 0 && !data_rvalid_i && ($urandom % 8 == 0)) data_rvalid_i = 1;
      end
    end
  end

  // Response monitor: pops the scoreboard on each Xmem response handshake.
  initial begin
    bit held;
    int lowcnt;
    logic [31:0] p_rd;
    logic [4:0] p_rg;
    logic p_st;
    rsp_t e;
    held = 0; lowcnt = 0; p_rd = 0; p_rg = 0; p_st = 0;
    xmem_rready_i = 1;
    forever begin
      @(negedge clk);
      if (held) begin
        chk("rsp_hold_valid", 32'(xmem_rvalid_o), 32'h1);
        chk("rsp_hold_rdata", xmem_rdata_o, p_rd);
        chk("rsp_hold_range", 32'(xmem_range_o), 32'(p_rg));
        chk("rsp_hold_status", 32'(xmem_status_o), 32'(p_st));
      end
      if (xmem_rvalid_o === 1'b1) begin
        chk("rsp_busy_ready", 32'(xmem_ready_o), 32'h0);
        if (!held) begin
          chk("rsp_expected", 32'(rsp_q.size() != 0), 32'h1);
          if (rsp_q.size() != 0 && rsp_q[0].lat >= 0)
            chk("rsp_latency", 32'(cyc - acc_cyc), 32'(rsp_q[0].lat));
          if (rr_mode == 2) lowcnt = 4;
        end
        if (rr_mode == 1) xmem_rready_i = 1;
        else if (rr_mode == 2) begin
          xmem_rready_i = (lowcnt == 0);
          if (lowcnt > 0) lowcnt--;
        end else xmem_rready_i = ($urandom % 4 != 0);
        if (xmem_rready_i && rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", xmem_rdata_o, e.rdata);
          chk("rsp_range", 32'(xmem_range_o), 32'(e.rng));
          chk("rsp_status", 32'(xmem_status_o), 32'(e.status));
        end
        held = !xmem_rready_i;
        p_rd = xmem_rdata_o; p_rg = xmem_range_o; p_st = xmem_status_o;
      end else begin
        held = 0;
        xmem_rready_i = (rr_mode != 0) ? 1'b1 : 1'($urandom);
      end
    end
  end

  initial begin
    int r0, t;
    logic [2:0] w;
    logic [2:0] legal_w [5];
    legal_w = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst_i = 1;
    xmem_valid_i = 0; xmem_laddr_i = 0; xmem_wdata_i = 0; xmem_width_i = 0;
    xmem_req_type_i = READ; xmem_mode_i = 0; xmem_spec_i = 0; xmem_endoftransaction_i = 0;
    for (int i = 0; i < 16; i++) set_word(32'h3000 + 32'(4 * i), $urandom);
    set_word(32'h2000, 32'h11223344);
    set_word(32'h1000, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(xmem_ready_o), 32'h1);
    chk("reset_rvalid", 32'(xmem_rvalid_o), 32'h0);
    chk("reset_rsp", {xmem_rdata_o[26:0], xmem_range_o} | 32'(xmem_status_o), 32'h0);
    chk("reset_req", 32'(data_req_o), 32'h0);
    chk("reset_obi", data_addr_o | data_wdata_o | 32'(data_be_o) | 32'(data_we_o), 32'h0);
    rst_i = 0;
    @(negedge clk);

    gnt_hold = 0; rv_dly = 1; rr_mode = 1;
    issue(32'h1000, 32'h0, 3'b010, 0, 0, 1); wait_done();
    set_word(32'h1000, 32'h80112233);
    issue(32'h1003, 32'h0, 3'b000, 0, 0, 1); wait_done();
    issue(32'h1003, 32'h0, 3'b100, 0, 0, 1); wait_done();
    issue(32'h2002, 32'h0000ABCD, 3'b001, 1, 0, 1); wait_done();
    issue(32'h2000, 32'h0, 3'b010, 0, 0, 1); wait_done();

    r0 = req_cycles;
    issue(32'h2001, 32'h0, 3'b010, 0, 0, 0); wait_done();
    issue(32'h3000, 32'h12345678, 3'b100, 1, 0, 0); wait_done();
    issue(32'h3004, 32'h12345678, 3'b010, 1, 1, 0); wait_done();
    chk("err_no_req", 32'(req_cycles), 32'(r0));

    gnt_hold = 3;
    issue(32'h3008, 32'hCAFEF00D, 3'b010, 1, 0, 0); wait_done();
    gnt_hold = 0; rr_mode = 2;
    issue(32'h300A, 32'h0, 3'b001, 0, 0, 1); wait_done();
    rr_mode = 1;

    gnt_hold = 1000;
    issue(32'h3010, 32'h0, 3'b010, 0, 0, 0);
    t = 0;
    while (data_req_o !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    chk("rst_test_req_seen", 32'(data_req_o), 32'h1);
    rst_i = 1;
    @(negedge clk);
    chk("rst_mid_req", 32'(data_req_o), 32'h0);
    chk("rst_mid_ready", 32'(xmem_ready_o), 32'h1);
    rst_i = 0;
    rsp_q.delete();
    bus_q.delete();
    gnt_hold = 0;
    issue(32'h3010, 32'h0, 3'b010, 0, 0, 1); wait_done();

    gnt_hold = -1; rv_dly = 0; rr_mode = 0;
    repeat (200) begin
      w = ($urandom % 4 == 0) ? 3'($urandom) : legal_w[$urandom % 5];
      issue(32'h3000 + ($urandom % 64), $urandom, w, 1'($urandom), ($urandom % 8 == 0), 0);
      wait_done();
    end
    repeat (3) @(negedge clk);
    finish_now();
  end

endmodule
